// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared memory, ALU and
// register file per instruction, with memory-ready stalls, timeout/illegal traps and retire count.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_src,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] instr_retired,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StLui      = 4'd11,
        StError    = 4'd12
    } state_e;

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpLoad = 7'b0000011;
    localparam logic [6:0] OpS    = 7'b0100011;
    localparam logic [6:0] OpB    = 7'b1100011;
    localparam logic [6:0] OpJ    = 7'b1101111;
    localparam logic [6:0] OpU    = 7'b0110111;

    localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [1:0]         err_q, err_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_wait, timeout_hit, retire;
    logic               br_valid, br_taken;
    logic               mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

    always_comb begin
        unique case (op)
            OpS:     imm_src = 3'b001;
            OpB:     imm_src = 3'b010;
            OpU:     imm_src = 3'b011;
            OpJ:     imm_src = 3'b100;
            default: imm_src = 3'b000;
        endcase
    end

    always_comb begin
        br_valid = 1'b1;
        br_taken = 1'b0;
        unique case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            default: br_valid = 1'b0;
        endcase
    end

    // The cycle that would make the wait count reach the limit traps, unless ready arrives.
    assign in_wait     = state_q inside {StFetch, StMemRead, StMemWrite};
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                         (32'(wait_q) + 32'd1 >= MEM_TIMEOUT);

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        unique case (state_q)
            StFetch: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    state_d    = StDecode;
                end else if (timeout_hit) begin
                    state_d = StError;
                    err_d   = 2'b10;
                end
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                unique case (op)
                    OpLoad, OpS: state_d = StMemAdr;
                    OpR:         state_d = StExecR;
                    OpI:         state_d = StExecI;
                    OpB:         state_d = StBranch;
                    OpJ:         state_d = StJal;
                    OpU:         state_d = StLui;
                    default: begin
                        state_d = StError;
                        err_d   = 2'b01;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OpLoad) begin
                    state_d = StMemRead;
                end else if (op == OpS) begin
                    state_d = StMemWrite;
                end else begin
                    state_d = StError;
                    err_d   = 2'b01;
                end
            end
            StMemRead: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout_hit) begin
                    state_d = StError;
                    err_d   = 2'b10;
                end
            end
            StMemWb: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            StMemWrite: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready) begin
                    state_d = StFetch;
                end else if (timeout_hit) begin
                    state_d = StError;
                    err_d   = 2'b10;
                end
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            StBranch: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                if (br_valid) begin
                    pc_write_c = br_taken;
                    state_d    = StFetch;
                end else begin
                    state_d = StError;
                    err_d   = 2'b01;
                end
            end
            StJal: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_d    = StAluWb;
            end
            StLui: begin
                result_src  = 2'b11;
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            default: ;
        endcase
    end

    // Stay-in-place only happens while waiting on memory, so any move clears the count.
    always_comb begin
        wait_d = '0;
        if (in_wait && (state_d == state_q) && (MEM_TIMEOUT != 0)) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    assign retire = (state_d == StFetch) &&
                    (state_q inside {StMemWb, StMemWrite, StAluWb, StBranch, StLui});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            err_q   <= 2'b00;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Strobes are gated by reset so an access in flight is dropped without side effects.
    assign mem_req       = mem_req_c & rst_n;
    assign mem_write     = mem_write_c & rst_n;
    assign ir_write      = ir_write_c & rst_n;
    assign pc_write      = pc_write_c & rst_n;
    assign reg_write     = reg_write_c & rst_n;
    assign err           = err_q;
    assign instr_retired = cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle vector table, hand sequences for traps/reset,
// and random instruction streams against an instruction-level path model.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_U    = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero, lt, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, err;
    logic [2:0] imm_src;
    logic [3:0] instr_retired;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct3       (funct3),
        .zero         (zero),
        .lt           (lt),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_write    (mem_write),
        .adr_src      (adr_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .result_src   (result_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .imm_src      (imm_src),
        .err          (err),
        .instr_retired(instr_retired),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       rdy, z, l;
        logic [3:0] st;
        logic [5:0] strb;
        logic [1:0] rs, a, b, aop;
        logic [2:0] imm;
        logic [3:0] ret;
    } vec_t;

    vec_t vecs[$];
    int   path[$];
    int   cur, waits, model_ret;
    bit   end_err, timed_out, is_mem;

    function automatic logic [5:0] strb_now();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write};
    endfunction

    function automatic bit exp_taken(input logic [2:0] f, input logic z, input logic l);
        case (f)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return l;
            3'b101:  return !l;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic [6:0] o, input logic [2:0] f, input logic r, input logic z,
                       input logic l, input logic [3:0] st, input logic [5:0] s,
                       input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] aop, input logic [2:0] imm, input logic [3:0] ret);
        vec_t v;
        v.op = o; v.f3 = f; v.rdy = r; v.z = z; v.l = l; v.st = st; v.strb = s;
        v.rs = rs; v.a = a; v.b = b; v.aop = aop; v.imm = imm; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic z, input logic l);
        mem_ready = r;
        zero      = z;
        lt        = l;
        #1;
    endtask

    // Called at a negedge; leaves the DUT released from reset in FETCH at the next negedge.
    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_strobes", 32'(strb_now()), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_retired", 32'(instr_retired), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_ret = 0;
    endtask

    task automatic expect_error(input logic [1:0] code, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("err_state", 32'(state_o), 32'd12);
            chk("err_code", 32'(err), 32'(code));
            chk("err_strobes", 32'(strb_now()), 32'd0);
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic mk_path(input int n, input int s2, input int s3, input int s4);
        path.delete();
        path.push_back(0);
        path.push_back(1);
        if (n > 2) path.push_back(s2);
        if (n > 3) path.push_back(s3);
        if (n > 4) path.push_back(s4);
    endtask

    initial begin
        rst_n = 1'b0; op = OP_R; funct3 = 3'b000; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
        model_ret = 0;

        // op, f3, rdy, z, lt, state, {req,wr,adr,ir,pc,rw}, rs, a, b, aop, imm, retired
        row(OP_R,    3'b000, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 4'd0);
        row(OP_R,    3'b000, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 4'd0);
        row(OP_R,    3'b000, 0, 0, 0, 4'd6,  6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
        row(OP_R,    3'b000, 0, 0, 0, 4'd8,  6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
        row(OP_LOAD, 3'b010, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1);
        row(OP_LOAD, 3'b010, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 4'd1);
        row(OP_LOAD, 3'b010, 0, 0, 0, 4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 4'd1);
        row(OP_LOAD, 3'b010, 0, 0, 0, 4'd3,  6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'd1);
        row(OP_LOAD, 3'b010, 0, 0, 0, 4'd3,  6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'd1);
        row(OP_LOAD, 3'b010, 0, 0, 0, 4'd3,  6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'd1);
        row(OP_LOAD, 3'b010, 1, 0, 0, 4'd3,  6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'd1);
        row(OP_LOAD, 3'b010, 0, 0, 0, 4'd4,  6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 4'd1);
        row(OP_S,    3'b010, 0, 0, 0, 4'd0,  6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 4'd2);
        row(OP_S,    3'b010, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b001, 4'd2);
        row(OP_S,    3'b010, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b001, 4'd2);
        row(OP_S,    3'b010, 0, 0, 0, 4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 4'd2);
        row(OP_S,    3'b010, 1, 0, 0, 4'd5,  6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 4'd2);
        row(OP_B,    3'b000, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010, 4'd3);
        row(OP_B,    3'b000, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 4'd3);
        row(OP_B,    3'b000, 0, 1, 0, 4'd9,  6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 4'd3);
        row(OP_B,    3'b000, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010, 4'd4);
        row(OP_B,    3'b000, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 4'd4);
        row(OP_B,    3'b000, 0, 0, 0, 4'd9,  6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 4'd4);
        row(OP_B,    3'b001, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010, 4'd5);
        row(OP_B,    3'b001, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 4'd5);
        row(OP_B,    3'b001, 0, 0, 0, 4'd9,  6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 4'd5);
        row(OP_B,    3'b100, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010, 4'd6);
        row(OP_B,    3'b100, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 4'd6);
        row(OP_B,    3'b100, 0, 0, 1, 4'd9,  6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 4'd6);
        row(OP_B,    3'b101, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010, 4'd7);
        row(OP_B,    3'b101, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 4'd7);
        row(OP_B,    3'b101, 0, 0, 1, 4'd9,  6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 4'd7);
        row(OP_J,    3'b000, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b100, 4'd8);
        row(OP_J,    3'b000, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100, 4'd8);
        row(OP_J,    3'b000, 0, 0, 0, 4'd10, 6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 3'b100, 4'd8);
        row(OP_J,    3'b000, 0, 0, 0, 4'd8,  6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100, 4'd8);
        row(OP_U,    3'b000, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b011, 4'd9);
        row(OP_U,    3'b000, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b011, 4'd9);
        row(OP_U,    3'b000, 0, 0, 0, 4'd11, 6'b000001, 2'b11, 2'b00, 2'b00, 2'b00, 3'b011, 4'd9);
        row(OP_I,    3'b000, 1, 0, 0, 4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 4'd10);
        row(OP_I,    3'b000, 0, 0, 0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 4'd10);
        row(OP_I,    3'b000, 0, 0, 0, 4'd7,  6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000, 4'd10);
        row(OP_I,    3'b000, 0, 0, 0, 4'd8,  6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'd10);
        row(OP_R,    3'b000, 0, 0, 0, 4'd0,  6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'd11);

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            op     = vecs[i].op;
            funct3 = vecs[i].f3;
            drive(vecs[i].rdy, vecs[i].z, vecs[i].l);
            chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
            chk($sformatf("vec%0d_strobes", i), 32'(strb_now()), 32'(vecs[i].strb));
            chk($sformatf("vec%0d_result_src", i), 32'(result_src), 32'(vecs[i].rs));
            chk($sformatf("vec%0d_alu_src_a", i), 32'(alu_src_a), 32'(vecs[i].a));
            chk($sformatf("vec%0d_alu_src_b", i), 32'(alu_src_b), 32'(vecs[i].b));
            chk($sformatf("vec%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].aop));
            chk($sformatf("vec%0d_imm_src", i), 32'(imm_src), 32'(vecs[i].imm));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
            chk($sformatf("vec%0d_retired", i), 32'(instr_retired), 32'(vecs[i].ret));
            @(negedge clk);
        end

        // Illegal opcode traps from DECODE and sticks until reset.
        do_reset();
        op = 7'b1111111;
        drive(1, 0, 0);
        chk("ill_fetch", 32'(state_o), 32'd0);
        @(negedge clk);
        drive(0, 0, 0);
        chk("ill_decode", 32'(state_o), 32'd1);
        @(negedge clk);
        expect_error(2'b01, 20);

        // Fetch timeout after four idle cycles.
        op = OP_R;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0);
            chk("to_wait_state", 32'(state_o), 32'd0);
            chk("to_wait_req", 32'(mem_req), 32'd1);
            @(negedge clk);
        end
        expect_error(2'b10, 2);

        // Ready on the limit cycle wins.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0);
            chk("late_wait", 32'(state_o), 32'd0);
            @(negedge clk);
        end
        drive(1, 0, 0);
        chk("late_ir_write", 32'(ir_write), 32'd1);
        @(negedge clk);
        drive(0, 0, 0);
        chk("late_decode", 32'(state_o), 32'd1);
        chk("late_err", 32'(err), 32'd0);
        @(negedge clk);

        // Reset in the middle of a store drops the write.
        do_reset();
        op = OP_S;
        drive(1, 0, 0); @(negedge clk);
        drive(0, 0, 0); @(negedge clk);
        drive(0, 0, 0); @(negedge clk);
        drive(0, 0, 0);
        chk("mid_memwrite", 32'(state_o), 32'd5);
        chk("mid_mem_write", 32'(mem_write), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("mid_rst_strobes", 32'(strb_now()), 32'd0);
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_retired", 32'(instr_retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_ret = 0;

        // Random instruction stream against the instruction-level path model.
        for (int n = 0; n < 300; n++) begin
            int unsigned k;
            k = $urandom_range(0, 39);
            end_err = 1'b0;
            funct3 = 3'($urandom_range(0, 7));
            if (k == 0) begin
                op = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0010111;
                mk_path(2, 0, 0, 0);
                end_err = 1'b1;
            end else if (k == 1) begin
                op = OP_B;
                funct3 = 3'b010 | 3'($urandom_range(0, 1)) | (3'($urandom_range(0, 1)) << 2);
                mk_path(3, 9, 0, 0);
                end_err = 1'b1;
            end else begin
                case (k % 7)
                    0: begin op = OP_R;    mk_path(4, 6, 8, 0);  end
                    1: begin op = OP_I;    mk_path(4, 7, 8, 0);  end
                    2: begin op = OP_LOAD; mk_path(5, 2, 3, 4);  end
                    3: begin op = OP_S;    mk_path(4, 2, 5, 0);  end
                    4: begin
                        op = OP_B;
                        funct3 = {1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1))};
                        mk_path(3, 9, 0, 0);
                    end
                    5: begin op = OP_J;    mk_path(4, 10, 8, 0); end
                    default: begin op = OP_U; mk_path(3, 11, 0, 0); end
                endcase
            end
            timed_out = 1'b0;
            waits = 0;
            while (path.size() > 0 && !timed_out) begin
                cur = path[0];
                drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
                is_mem = (cur == 0) || (cur == 3) || (cur == 5);
                chk("rnd_state", 32'(state_o), 32'(cur));
                chk("rnd_err", 32'(err), 32'd0);
                chk("rnd_retired", 32'(instr_retired), 32'(model_ret));
                chk("rnd_mem_req", 32'(mem_req), 32'(is_mem));
                chk("rnd_mem_write", 32'(mem_write), 32'(cur == 5));
                chk("rnd_reg_write", 32'(reg_write), 32'((cur == 4) || (cur == 8) || (cur == 11)));
                chk("rnd_ir_write", 32'(ir_write), 32'((cur == 0) && mem_ready));
                chk("rnd_pc_write", 32'(pc_write),
                    32'((cur == 0) ? mem_ready :
                        (cur == 9) ? exp_taken(funct3, zero, lt) : (cur == 10)));
                if (is_mem && !mem_ready) begin
                    waits++;
                    if (waits == 4) timed_out = 1'b1;
                end else begin
                    void'(path.pop_front());
                    waits = 0;
                end
                @(negedge clk);
            end
            if (timed_out) begin
                expect_error(2'b10, 2);
            end else if (end_err) begin
                expect_error(2'b01, 2);
            end else begin
                model_ret = (model_ret + 1) % 16;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences one shared instruction/data memory, the ALU and the register file across several cycles per instruction.
- Decodes `op`/`funct3` into per-state datapath selects and qualifies branches with ALU flags.
- Stalls on a memory ready handshake, flags illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 255: max cycles a memory state waits for `mem_ready`. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- op  in  7  instruction[6:0] from IR
- funct3  in  3  instruction[14:12] from IR
- zero  in  1  ALU result == 0
- lt  in  1  ALU signed less-than flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  write strobe, only with `mem_req`
- adr_src  out  1  memory address select: 0 PC, 1 ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- result_src  out  2  result bus select: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  ALU B select: 00 rs2, 01 ImmExt, 10 constant 4
- alu_op  out  2  ALU op class: 00 add, 01 sub/compare, 10 funct-decoded
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J
- err  out  2  error code: 00 none, 01 illegal, 10 memory timeout
- instr_retired  out  CNT_W  count of completed instructions
- state_o  out  4  current state encoding, debug

Behaviour:
- Opcodes:
  - R 0110011, I 0010011, LOAD 0000011, S 0100011, B 1100011, J 1101111, U 0110111.
- `imm_src`:
  - Combinational from `op` in every state: I/LOAD→000, S→001, B→010, U→011, J→100, else 000.
- Output defaults:
  - Every output not listed for a state is 0, including all selects.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, ERROR=12.
- FETCH: `mem_req`=1, `adr_src`=0.
  - Holds while `mem_ready`=0.
  - On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `a`=00, `b`=10, `alu_op`=00, `result_src`=10 (PC←PC+4) → DECODE.
- DECODE: `a`=01, `b`=01, `alu_op`=00 (ALUOut←OldPC+imm).
  - LOAD/S→MEMADR, R→EXEC_R, I→EXEC_I, B→BRANCH, J→JAL, U→LUI.
  - Any other `op`→ERROR with `err`=01.
- MEMADR: `a`=10, `b`=01, `alu_op`=00 → MEMREAD if LOAD, MEMWRITE if S.
- MEMREAD: `mem_req`=1, `adr_src`=1; holds until `mem_ready` → MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1 → FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1; holds until `mem_ready` → FETCH.
- EXEC_R: `a`=10, `b`=00, `alu_op`=10 → ALUWB.
- EXEC_I: `a`=10, `b`=01, `alu_op`=10 → ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1 → FETCH.
- BRANCH: `a`=10, `b`=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = taken, where taken is: 000 `zero`, 001 !`zero`, 100 `lt`, 101 !`lt` → FETCH.
  - Any other `funct3` → ERROR, `err`=01, `pc_write`=0.
- JAL: `a`=01, `b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1 (PC←target) → ALUWB (rd←OldPC+4).
- LUI: `result_src`=11, `reg_write`=1 → FETCH.
- ERROR:
  - All strobes 0; `err` holds its code.
  - Remains in ERROR until reset.
- Memory timeout:
  - Wait counter clears on every entry to FETCH/MEMREAD/MEMWRITE.
  - Increments each cycle the FSM sits in one of these states with `mem_ready`=0.
  - When MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with `mem_ready` still 0 → ERROR, `err`=10.
  - `mem_ready` on the same cycle as reaching the limit wins: normal transition.
- `instr_retired`:
  - +1 on each transition into FETCH from MEMWB/MEMWRITE/ALUWB/BRANCH/LUI.
  - Wraps modulo 2^CNT_W.
- Reset (async, `rst_n`=0):
  - state=FETCH, counters=0, `err`=00.
  - Outputs follow FETCH decode immediately: `mem_req`=1 only after `rst_n` deasserts.
  - `mem_req`, `pc_write`, `reg_write`, `ir_write`, `mem_write` are forced 0 while `rst_n`=0.
  - Reset mid-access abandons the access without writes.
- CPI:
  - LOAD 5, S 4, R/I 4, B 3, J 4, U 3, assuming `mem_ready` on first request cycle.
  - Each 0-ready cycle adds 1.

Test Plan:
- add x3,x1,x2 (op=0110011), `mem_ready`=1 always → states 0,1,6,8,0; `reg_write`=1 only in ALUWB; `instr_retired` 0→1.
- lw (op=0000011), `mem_ready` low 3 cycles in MEMREAD → 0,1,2,3,3,3,3,4,0; `adr_src`=1 throughout MEMREAD; `result_src`=01 in MEMWB.
- beq with `zero`=1, then `zero`=0 → `pc_write`=1 then 0 in BRANCH; both retire in 3 cycles; bne with `zero`=0 → `pc_write`=1.
- jal (op=1101111) → JAL `pc_write`=1, `result_src`=00; ALUWB `reg_write`=1; `imm_src`=100 in all states.
- op=1111111 → DECODE→ERROR, `err`=01, all strobes 0 for 20 cycles; `rst_n` pulse → FETCH, `err`=00.
- MEM_TIMEOUT=4, `mem_ready` held 0 in FETCH → ERROR after 4 wait cycles, `err`=10; repeat with `mem_ready`=1 on 4th cycle → DECODE, `err`=00.
